// File: rtl/systolic_array.sv
// Weight-stationary NxN signed GEMM tile: activations skew in from the left, psums flow down,
// and a deskew stage realigns each output row. result_ready low freezes the whole pipeline.
module systolic_array #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               clear_acc,
    input  logic [15:0]                        cfg_k_tiles,
    input  logic                               weight_load_en,
    input  logic [$clog2(ARRAY_SIZE)-1:0]      weight_load_col,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   weight_load_data,
    input  logic                               act_valid,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   act_data,
    output logic                               act_ready,
    output logic                               result_valid,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]    result_data,
    input  logic                               result_ready,
    output logic                               busy,
    output logic                               done
);
    localparam int N  = ARRAY_SIZE;
    localparam int L  = 2 * ARRAY_SIZE;
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;
    logic   done_r, done_next;

    logic [15:0]   acc_cnt, k_tiles;
    logic [L-1:0]  vpipe;
    logic          out_v, lead_seen;
    logic          en, accept, start_run, clear, lead_beat, last_beat;

    logic signed [DATA_WIDTH-1:0] w     [N][N];
    logic signed [DATA_WIDTH-1:0] skew  [N][N];
    logic signed [DATA_WIDTH-1:0] a_reg [N][N];
    logic signed [ACC_WIDTH-1:0]  ps    [N][N];
    logic signed [ACC_WIDTH-1:0]  dsk   [N][N-1];
    logic [N*ACC_WIDTH-1:0]       out_reg;

    logic signed [DATA_WIDTH-1:0] a_in    [N][N];
    logic signed [ACC_WIDTH-1:0]  p_in    [N][N];
    logic signed [PW-1:0]         prod    [N][N];
    logic signed [ACC_WIDTH-1:0]  mac     [N][N];
    logic signed [ACC_WIDTH-1:0]  dsk_out [N];

    assign en        = result_ready;
    assign busy      = (state == RUN);
    assign done      = done_r;
    assign act_ready = busy & result_ready & (acc_cnt < k_tiles);
    assign accept    = act_valid & act_ready;
    assign start_run = (state == IDLE) & start & (cfg_k_tiles != 16'd0);
    assign clear     = (state == IDLE) & start & clear_acc;

    // vpipe[L-1] marks a row arriving at the output register; the first such token of a run
    // also presents one leading beat showing the register's prior (cleared) contents.
    assign lead_beat    = vpipe[L-1] & ~lead_seen;
    assign last_beat    = en & out_v & (vpipe == '0) & (acc_cnt == k_tiles);
    assign result_valid = busy & (lead_beat | out_v);
    assign result_data  = out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_k_tiles == 16'd0) done_next  = 1'b1;
                    else                      state_next = RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt   <= '0;
            k_tiles   <= '0;
            vpipe     <= '0;
            out_v     <= 1'b0;
            lead_seen <= 1'b0;
        end else if (start_run) begin
            acc_cnt   <= '0;
            k_tiles   <= cfg_k_tiles;
            vpipe     <= '0;
            out_v     <= 1'b0;
            lead_seen <= 1'b0;
        end else if (busy && en) begin
            if (accept) acc_cnt <= acc_cnt + 16'd1;
            vpipe <= {vpipe[L-2:0], accept};
            out_v <= vpipe[L-1];
            if (lead_beat) lead_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++)
                for (int unsigned n = 0; n < N; n++)
                    w[k][n] <= '0;
        end else if (weight_load_en && state == IDLE) begin
            for (int unsigned k = 0; k < N; k++)
                w[k][weight_load_col] <= weight_load_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned n = 0; n < N; n++) begin
                if (n == 0) a_in[k][n] = skew[k][k];
                else        a_in[k][n] = a_reg[k][n-1];
                if (k == 0) p_in[k][n] = '0;
                else        p_in[k][n] = ps[k-1][n];
                prod[k][n] = PW'(a_in[k][n]) * PW'(w[k][n]);
                mac[k][n]  = p_in[k][n] + ACC_WIDTH'(prod[k][n]);
            end
        end
        for (int unsigned n = 0; n < N; n++) begin
            if (n == N - 1) dsk_out[n] = ps[N-1][n];
            else            dsk_out[n] = dsk[n][N-2-n];
        end
    end

    // Idle cycles feed zeros into the skew chain, so bubbles leave the psum chain clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                for (int unsigned n = 0; n < N; n++) begin
                    skew[k][n]  <= '0;
                    a_reg[k][n] <= '0;
                    ps[k][n]    <= '0;
                end
                for (int unsigned j = 0; j < N - 1; j++) dsk[k][j] <= '0;
            end
            out_reg <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k < N; k++) begin
                for (int unsigned n = 0; n < N; n++) ps[k][n] <= '0;
                for (int unsigned j = 0; j < N - 1; j++) dsk[k][j] <= '0;
            end
            out_reg <= '0;
        end else if (en) begin
            for (int unsigned k = 0; k < N; k++) begin
                skew[k][0] <= accept ? act_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int unsigned j = 1; j < N; j++) skew[k][j] <= skew[k][j-1];
                for (int unsigned n = 0; n < N; n++) begin
                    a_reg[k][n] <= a_in[k][n];
                    ps[k][n]    <= mac[k][n];
                end
            end
            for (int unsigned n = 0; n < N; n++) begin
                dsk[n][0] <= ps[N-1][n];
                for (int unsigned j = 1; j < N - 1; j++) dsk[n][j] <= dsk[n][j-1];
            end
            if (vpipe[L-1]) begin
                for (int unsigned n = 0; n < N; n++)
                    out_reg[n*ACC_WIDTH +: ACC_WIDTH] <= dsk_out[n];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: expected rows are computed from a bench-side weight
// copy when each activation is accepted, and popped as result beats are handed off.
module tb_systolic_array;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int RW = N * AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, clear_acc, weight_load_en, act_valid, result_ready;
    logic [15:0]       cfg_k_tiles;
    logic [1:0]        weight_load_col;
    logic [N*DW-1:0]   weight_load_data, act_data;
    logic              act_ready, result_valid, busy, done;
    logic [RW-1:0]     result_data;

    systolic_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_acc(clear_acc),
        .cfg_k_tiles(cfg_k_tiles), .weight_load_en(weight_load_en),
        .weight_load_col(weight_load_col), .weight_load_data(weight_load_data),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .result_valid(result_valid), .result_data(result_data),
        .result_ready(result_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int nbeats, ndone, first_vcyc, done_cyc;
    int bw [N][N];
    logic [RW-1:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input int v0, input int v1, input int v2, input int v3);
        logic [N*DW-1:0] r;
        r[7:0]   = v0[7:0];
        r[15:8]  = v1[7:0];
        r[23:16] = v2[7:0];
        r[31:24] = v3[7:0];
        return r;
    endfunction

    function automatic logic [RW-1:0] model_row(input logic [N*DW-1:0] a);
        logic [RW-1:0] r;
        logic [DW-1:0] lane;
        int s;
        for (int n = 0; n < N; n++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
                lane = a[k*DW +: DW];
                s += int'($signed(lane)) * bw[k][n];
            end
            r[n*AW +: AW] = s;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid && result_ready) begin
                if (nbeats == 0) first_vcyc = cyc;
                nbeats++;
                if (sb.size() == 0) check("sb_nonempty", RW'(sb.size()), RW'(1));
                else                check("beat", result_data, sb.pop_front());
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                check("busy_at_done", RW'(busy), RW'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        for (int n = 0; n < N; n++) begin
            weight_load_en   = 1'b1;
            weight_load_col  = 2'(n);
            weight_load_data = pack(bw[0][n], bw[1][n], bw[2][n], bw[3][n]);
            tick();
        end
        weight_load_en = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < N; k++)
            for (int n = 0; n < N; n++)
                bw[k][n] = v;
    endtask

    task automatic start_run(input int m);
        nbeats = 0; ndone = 0; first_vcyc = -1; done_cyc = -1;
        start = 1'b1; clear_acc = 1'b1; cfg_k_tiles = 16'(m);
        tick();
        start = 1'b0; clear_acc = 1'b0;
        if (m > 0) sb.push_back('0);
    endtask

    task automatic send_vec(input logic [N*DW-1:0] a, output int t0);
        bit got = 0;
        t0 = -1;
        act_valid = 1'b1;
        act_data  = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (act_ready) begin
                got = 1;
                t0  = cyc + 1;
                sb.push_back(model_row(a));
            end
            tick();
        end
        act_valid = 1'b0;
        if (!got) check("accept_timeout", RW'(0), RW'(1));
    endtask

    task automatic wait_done(input int exp_beats);
        for (int i = 0; i < 400 && ndone == 0; i++) tick();
        repeat (3) tick();
        check("done_count", RW'(ndone), RW'(1));
        check("beat_count", RW'(nbeats), RW'(exp_beats));
        check("sb_drained", RW'(sb.size()), RW'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rvalid"}, RW'(result_valid), RW'(0));
        check({tag, "_aready"}, RW'(act_ready), RW'(0));
        check({tag, "_busy"},   RW'(busy), RW'(0));
        check({tag, "_done"},   RW'(done), RW'(0));
        check({tag, "_rdata"},  result_data, '0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n = 1'b0; start = 1'b0; clear_acc = 1'b0; cfg_k_tiles = '0;
        weight_load_en = 1'b0; weight_load_col = '0; weight_load_data = '0;
        act_valid = 1'b0; act_data = '0; result_ready = 1'b1;
        set_all(0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Identity in the top-left 2x2
        bw[0][0] = 1; bw[1][1] = 1;
        load_weights();
        start_run(4);
        send_vec(pack(1, 2, 0, 0), t0);
        send_vec(pack(3, 4, 0, 0), t0);
        send_vec(pack(0, 0, 0, 0), t0);
        send_vec(pack(0, 0, 0, 0), t0);
        wait_done(5);

        // Signed extremes
        set_all(-128);
        load_weights();
        start_run(1);
        send_vec(pack(-128, -128, -128, -128), t0);
        wait_done(2);
        set_all(127);
        load_weights();
        start_run(1);
        send_vec(pack(-1, -1, -1, -1), t0);
        wait_done(2);

        // Latency of a single vector
        for (int k = 0; k < N; k++)
            for (int n = 0; n < N; n++)
                bw[k][n] = k * 4 + n - 7;
        load_weights();
        start_run(1);
        send_vec(pack(3, -5, 7, 100), t0);
        wait_done(2);
        check("first_valid_cyc", RW'(first_vcyc), RW'(t0 + 7));
        check("done_cyc", RW'(done_cyc), RW'(t0 + 9));

        // Backpressure mid-burst
        start_run(12);
        fork
            begin
                int tt;
                for (int i = 0; i < 12; i++) send_vec(N*DW'($urandom), tt);
            end
            begin
                repeat (9) tick();
                result_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_aready", RW'(act_ready), RW'(0));
                    if (result_valid && sb.size() > 0) check("stall_data", result_data, sb[0]);
                    tick();
                end
                result_ready = 1'b1;
            end
        join
        wait_done(13);

        // Weight load and start while busy are ignored
        start_run(6);
        fork
            begin
                int tt;
                for (int i = 0; i < 6; i++) send_vec(pack(i + 1, -i, 2 * i, 9 - i), tt);
            end
            begin
                tick(); tick();
                weight_load_en = 1'b1; weight_load_col = 2'd0;
                weight_load_data = pack(99, 99, 99, 99);
                start = 1'b1; cfg_k_tiles = 16'd2; clear_acc = 1'b1;
                tick();
                weight_load_en = 1'b0; start = 1'b0; clear_acc = 1'b0;
            end
        join
        wait_done(7);
        start_run(1);
        send_vec(pack(1, 1, 1, 1), t0);
        wait_done(2);

        // Zero-length run
        start_run(0);
        check("k0_done", RW'(done), RW'(1));
        check("k0_busy", RW'(busy), RW'(0));
        tick();
        check("k0_done_clr", RW'(done), RW'(0));
        repeat (3) tick();
        check("k0_beats", RW'(nbeats), RW'(0));
        check("k0_done_count", RW'(ndone), RW'(1));

        // Reset while streaming
        start_run(8);
        send_vec(pack(4, 3, 2, 1), t0);
        send_vec(pack(5, 6, 7, 8), t0);
        send_vec(pack(9, 9, 9, 9), t0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        set_all(0);
        start_run(1);
        send_vec(pack(5, 6, 7, 8), t0);
        wait_done(2);
        for (int k = 0; k < N; k++)
            for (int n = 0; n < N; n++)
                bw[k][n] = (k == n) ? 2 : -1;
        load_weights();
        start_run(2);
        send_vec(pack(5, 6, 7, 8), t0);
        send_vec(pack(-3, 0, 12, -1), t0);
        wait_done(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
